sd_sync_align: RTL and testbench

- Sits directly downstream of the scandoubler, in the clk_sys domain, and feeds the VGA/HDMI output path.
- Re-times the doubled vsync so that it changes only on the hsync leading edge, one line late. This closes the scandoubler's open "delay vsync one line" item.
- Measures line length and flags loss of sync.
- Generates hblank, vblank and de from programmable active-window parameters, and blanks RGB outside the window.

---
 rtl/sd_video_pkg.sv | 27 ++
 rtl/sd_sync_edge.sv | 25 ++
 rtl/sd_sync_align.sv | 133 +++++++++++++
 tb/tb_sd_sync_align.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sd_video_pkg.sv
// Shared video timing types and default active-window geometry for the
// scandoubler output path (also used by the OSD).
package sd_video_pkg;

  localparam int H_W = 11;
  localparam int V_W = 10;

  typedef struct packed {
    logic [5:0] r;
    logic [5:0] g;
    logic [5:0] b;
  } rgb6_t;

  localparam logic [H_W-1:0] DEF_H_START    = 11'd96;
  localparam logic [H_W-1:0] DEF_H_LEN      = 11'd512;
  localparam logic [V_W-1:0] DEF_V_START    = 10'd35;
  localparam logic [V_W-1:0] DEF_V_LEN      = 10'd384;
  localparam logic [H_W-1:0] DEF_LOST_LIMIT = 11'd2047;

  // 12-bit operands so start+len cannot wrap for any 11-bit window
  function automatic logic in_window(input logic [11:0] pos,
                                     input logic [11:0] start,
                                     input logic [11:0] len);
    return (pos >= start) && (pos < (start + len));
  endfunction

endpackage

// File: rtl/sd_sync_edge.sv
// Registered edge detector for one sync line; previous level resets high
// (inactive for active-low syncs), rise/fall are valid on ce cycles.
module sd_sync_edge (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_ce,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic r_d;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_d <= 1'b1;
    end else if (i_ce) begin
      r_d <= i_d;
    end
  end

  assign o_rise = ~r_d & i_d;
  assign o_fall = r_d & ~i_d;

endmodule

// File: rtl/sd_sync_align.sv
// Aligns vsync to the hsync leading edge (one line late), measures line length,
// detects sync loss and generates blanking/de; all outputs 1 ce_pix after input.
module sd_sync_align
  import sd_video_pkg::*;
#(
  parameter logic [H_W-1:0] H_START    = DEF_H_START,
  parameter logic [H_W-1:0] H_LEN      = DEF_H_LEN,
  parameter logic [V_W-1:0] V_START    = DEF_V_START,
  parameter logic [V_W-1:0] V_LEN      = DEF_V_LEN,
  parameter logic [H_W-1:0] LOST_LIMIT = DEF_LOST_LIMIT
) (
  input  logic           clk_sys,
  input  logic           reset,
  input  logic           ce_pix,
  input  logic           hs_in,
  input  logic           vs_in,
  input  logic [5:0]     r_in,
  input  logic [5:0]     g_in,
  input  logic [5:0]     b_in,
  output logic           hs_out,
  output logic           vs_out,
  output logic           hblank,
  output logic           vblank,
  output logic           de,
  output logic [5:0]     r_out,
  output logic [5:0]     g_out,
  output logic [5:0]     b_out,
  output logic [H_W-1:0] line_len,
  output logic           lost
);

  logic w_hs_fall_raw, w_unused_hs_rise, w_vs_rise, w_vs_fall;
  logic w_hs_fall, w_vs_edge;

  sd_sync_edge u_hs_edge (
    .i_clk(clk_sys), .i_reset(reset), .i_ce(ce_pix), .i_d(hs_in),
    .o_rise(w_unused_hs_rise), .o_fall(w_hs_fall_raw)
  );

  sd_sync_edge u_vs_edge (
    .i_clk(clk_sys), .i_reset(reset), .i_ce(ce_pix), .i_d(vs_in),
    .o_rise(w_vs_rise), .o_fall(w_vs_fall)
  );

  assign w_hs_fall = ce_pix & w_hs_fall_raw;
  assign w_vs_edge = ce_pix & (w_vs_rise | w_vs_fall);

  logic [H_W-1:0] r_hcnt;
  logic [V_W-1:0] r_vcnt;
  logic           r_vs_pend, r_vs_lvl, r_vs_a;
  rgb6_t          r_pix;

  logic [H_W-1:0] w_hcnt_n;
  logic [V_W-1:0] w_vcnt_n;
  logic           w_lost_n, w_hwin, w_vwin, w_de_n;
  logic [11:0]    w_len_sum;
  rgb6_t          w_pix_in;

  assign w_pix_in = '{r: r_in, g: g_in, b: b_in};

  // Next-state counters; the window is decoded on these so it lines up with the pixel being registered
  always_comb begin
    w_hcnt_n = r_hcnt;
    w_vcnt_n = r_vcnt;
    w_lost_n = lost;
    if (w_hs_fall) begin
      w_hcnt_n = '0;
      w_lost_n = 1'b0;
      if (vs_out && !r_vs_a) begin
        w_vcnt_n = '0;
      end else if (r_vcnt != '1) begin
        w_vcnt_n = r_vcnt + 1'b1;
      end
    end else begin
      if (r_hcnt != LOST_LIMIT) begin
        w_hcnt_n = r_hcnt + 1'b1;
      end
      if (w_hcnt_n == LOST_LIMIT) begin
        w_lost_n = 1'b1;
      end
    end
  end

  assign w_hwin    = in_window({1'b0, w_hcnt_n}, {1'b0, H_START}, {1'b0, H_LEN});
  assign w_vwin    = in_window({2'b0, w_vcnt_n}, {2'b0, V_START}, {2'b0, V_LEN});
  assign w_de_n    = w_hwin & w_vwin & ~w_lost_n;
  assign w_len_sum = {1'b0, r_hcnt} + 12'd1;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_hcnt    <= '0;
      r_vcnt    <= '0;
      r_vs_pend <= 1'b0;
      r_vs_lvl  <= 1'b1;
      r_vs_a    <= 1'b1;
      r_pix     <= '0;
      hs_out    <= 1'b1;
      vs_out    <= 1'b1;
      hblank    <= 1'b1;
      vblank    <= 1'b1;
      de        <= 1'b0;
      line_len  <= '0;
      lost      <= 1'b1;
    end else if (ce_pix) begin
      r_hcnt <= w_hcnt_n;
      r_vcnt <= w_vcnt_n;
      lost   <= w_lost_n;
      hs_out <= hs_in;
      hblank <= ~w_hwin;
      vblank <= ~w_vwin | w_lost_n;
      de     <= w_de_n;
      r_pix  <= w_de_n ? w_pix_in : '0;
      if (w_hs_fall) begin
        // A line that ran past the lost limit reports the largest representable length
        line_len <= w_len_sum[11] ? '1 : w_len_sum[H_W-1:0];
        vs_out   <= r_vs_a;
      end
      // A fresh vs edge always defers its commit to a later hs leading edge
      if (w_vs_edge) begin
        r_vs_pend <= 1'b1;
        r_vs_lvl  <= vs_in;
      end else if (w_hs_fall && r_vs_pend) begin
        r_vs_pend <= 1'b0;
        r_vs_a    <= r_vs_lvl;
      end
    end
  end

  assign r_out = r_pix.r;
  assign g_out = r_pix.g;
  assign b_out = r_pix.b;

endmodule

// File: tb/tb_sd_sync_align.sv
// Directed bench for sd_sync_align using a reduced active window
// (H 10..29, V 4..9) so each frame is only a few hundred pixels.
module tb_sd_sync_align;

  logic        clk_sys = 1'b0;
  logic        reset, ce_pix, hs_in, vs_in;
  logic [5:0]  r_in, g_in, b_in;
  logic        hs_out, vs_out, hblank, vblank, de, lost;
  logic [5:0]  r_out, g_out, b_out;
  logic [10:0] line_len;

  sd_sync_align #(
    .H_START(11'd10), .H_LEN(11'd20), .V_START(10'd4), .V_LEN(10'd6)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix),
    .hs_in(hs_in), .vs_in(vs_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hs_out(hs_out), .vs_out(vs_out), .hblank(hblank), .vblank(vblank), .de(de),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .line_len(line_len), .lost(lost)
  );

  always #5 clk_sys = ~clk_sys;

  localparam logic [39:0] RST_EXP = {5'd0, 6'b111101, 18'd0, 11'd0};

  int          total = 0;
  int          bad = 0;
  int          de_cnt, first_de, gap_diff, frame_de;
  int          rgb_bad = 0;
  logic        vs_start, vs_end, hs0, lost0;
  logic [5:0]  first_r;
  logic [10:0] ll0;
  logic [39:0] rst_snap;

  function automatic logic [39:0] outs();
    return {5'd0, hs_out, vs_out, hblank, vblank, de, lost, r_out, g_out, b_out, line_len};
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One line: hs low for pixels 0..3; optional vs change, ce gap or reset at a given pixel
  task automatic do_line(input int len, input int vs_pos, input logic vs_val,
                         input int gap_at, input int rst_at);
    logic [39:0] snap;
    logic        sv_vs;
    de_cnt   = 0;
    first_de = -1;
    for (int k = 0; k < len; k++) begin
      if (k == gap_at) begin
        snap     = outs();
        sv_vs    = vs_in;
        gap_diff = 0;
        ce_pix   = 1'b0;
        hs_in    = 1'b0;
        vs_in    = ~sv_vs;
        r_in     = 6'h3F;
        for (int j = 0; j < 50; j++) begin
          tick();
          if (outs() !== snap) gap_diff++;
        end
        vs_in = sv_vs;
      end
      hs_in = (k < 4) ? 1'b0 : 1'b1;
      if (k == vs_pos) vs_in = vs_val;
      r_in   = k[5:0];
      g_in   = ~k[5:0];
      b_in   = 6'h3F;
      ce_pix = (k != rst_at);
      reset  = (k == rst_at);
      tick();
      if (k == rst_at) rst_snap = outs();
      reset = 1'b0;
      if (de) begin
        if (first_de < 0) begin
          first_de = k;
          first_r  = r_out;
        end
        de_cnt++;
      end else if ({r_out, g_out, b_out} != 18'd0) begin
        rgb_bad++;
      end
      if (k == 0) begin
        vs_start = vs_out;
        hs0      = hs_out;
        lost0    = lost;
        ll0      = line_len;
      end
    end
    vs_end = vs_out;
  endtask

  initial begin
    reset = 1'b1; ce_pix = 1'b1; hs_in = 1'b1; vs_in = 1'b1;
    r_in = 6'h15; g_in = 6'h2A; b_in = 6'h3F;
    tick();
    tick();
    chk("rst_hs_out", hs_out, 1);
    chk("rst_vs_out", vs_out, 1);
    chk("rst_hblank", hblank, 1);
    chk("rst_vblank", vblank, 1);
    chk("rst_de", de, 0);
    chk("rst_rgb", {r_out, g_out, b_out}, 0);
    chk("rst_line_len", line_len, 0);
    chk("rst_lost", lost, 1);
    reset = 1'b0;

    do_line(40, -1, 1'b1, -1, -1);
    chk("lost_clear", lost, 0);
    do_line(40, -1, 1'b1, -1, -1);
    chk("line_len_40", line_len, 40);
    chk("hs_out_delay", hs0, 0);

    // vs falls mid-line: commit at next hs edge, visible one line later
    do_line(40, 20, 1'b0, -1, -1);
    chk("vs_hold_a", vs_end, 1);
    do_line(40, -1, 1'b0, -1, -1);
    chk("vs_hold_b_start", vs_start, 1);
    chk("vs_hold_b_end", vs_end, 1);

    frame_de = 0;
    for (int i = 0; i < 12; i++) begin
      do_line(40, (i == 1) ? 20 : -1, 1'b1, -1, -1);
      frame_de += de_cnt;
      if (i == 0) chk("vs_fall_c", vs_start, 0);
      if (i == 2) chk("vs_low_c2", vs_start, 0);
      if (i == 3) chk("vs_rise_c3", vs_start, 1);
      chk("de_line", de_cnt, (i >= 4 && i < 10) ? 20 : 0);
      if (i == 4) begin
        chk("first_de_pos", first_de, 10);
        chk("first_de_rgb", first_r, 10);
      end
    end
    chk("frame_de", frame_de, 120);

    // vs edge coincident with hs leading edge
    do_line(40, 0, 1'b0, -1, -1);
    chk("vs_coinc_d0", vs_start, 1);
    do_line(40, -1, 1'b0, -1, -1);
    chk("vs_coinc_d1", vs_start, 1);
    do_line(40, -1, 1'b0, -1, -1);
    chk("vs_coinc_d2", vs_start, 0);
    do_line(40, 20, 1'b1, -1, -1);
    do_line(40, -1, 1'b1, -1, -1);
    do_line(40, -1, 1'b1, -1, -1);

    // ce_pix gap inside the active region of vcnt 4
    do_line(40, -1, 1'b1, 15, -1);
    chk("gap_frozen", gap_diff, 0);
    chk("gap_de_cnt", de_cnt, 20);

    // hs held high: lost asserts at hcnt 2047 on an otherwise active line
    for (int k = 0; k < 2100; k++) begin
      hs_in = (k < 4) ? 1'b0 : 1'b1;
      r_in = k[5:0]; ce_pix = 1'b1;
      tick();
      if (k == 0) chk("len_after_gap", line_len, 40);
      if (k == 2046) begin
        chk("lost_before", lost, 0);
        chk("vblank_before", vblank, 0);
      end
      if (k == 2047) begin
        chk("lost_at_limit", lost, 1);
        chk("vblank_lost", vblank, 1);
        chk("de_lost", de, 0);
        chk("rgb_lost", {r_out, g_out, b_out}, 0);
      end
    end
    chk("lost_held", lost, 1);
    do_line(40, -1, 1'b1, -1, -1);
    chk("len_sat", ll0, 11'd2047);
    chk("lost_recover", lost0, 0);
    chk("de_recover", de_cnt, 20);

    // reset mid-line (with ce_pix low) on active line vcnt 7
    do_line(40, -1, 1'b1, -1, 20);
    chk("mid_reset_state", rst_snap, RST_EXP);
    chk("mid_reset_de", de_cnt, 10);
    do_line(40, -1, 1'b1, -1, -1);
    chk("reset_lost_clear", lost0, 0);
    do_line(40, 20, 1'b0, -1, -1);
    do_line(40, -1, 1'b0, -1, -1);
    chk("reset_vs_hold", vs_start, 1);
    for (int i = 0; i < 6; i++) begin
      do_line(40, -1, 1'b0, -1, -1);
      if (i == 0) chk("reset_vs_fall", vs_start, 0);
      chk("reset_de_line", de_cnt, (i >= 4) ? 20 : 0);
      if (i == 4) chk("reset_first_de", first_de, 10);
    end
    chk("rgb_blank", rgb_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
